// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RESULT_SRC_W = 2;

    localparam logic [RESULT_SRC_W-1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        MISS   = 2'b01,
        REFILL = 2'b10
    } mem_state_e;

    // Stall/flush controls for every pipeline register.
    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic stall_w;
        logic flush_d;
        logic flush_e;
    } pipe_ctrl_t;

    // Operand bypass select; the younger M result beats the W result, x0 never forwards.
    function automatic fwd_sel_e fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] rd_m,
        input logic [REG_ADDR_W-1:0] rd_w,
        input logic                  reg_write_m,
        input logic                  reg_write_w
    );
        fwd_sel_e sel;
        sel = FWD_NONE;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_stall_fsm.sv
// Data-cache miss sequencer: freezes the pipeline from the miss cycle until one cycle after refill,
// with a sticky watchdog flag for misses that take too long.
module mem_stall_fsm
    import hazard_pkg::*;
#(
    parameter int unsigned MISS_TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic DCacheMissM,
    input  logic DCacheReadyM,
    output logic MemStall,
    output logic MissTimeout
);

    localparam int unsigned MISS_CNT_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [MISS_CNT_W-1:0] MISS_CNT_MAX = MISS_CNT_W'(MISS_TIMEOUT);

    mem_state_e            state;
    mem_state_e            state_nxt;
    logic [MISS_CNT_W-1:0] miss_cnt;
    logic [MISS_CNT_W-1:0] miss_cnt_nxt;
    logic                  timeout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            miss_cnt    <= '0;
            MissTimeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            miss_cnt    <= miss_cnt_nxt;
            MissTimeout <= timeout_nxt;
        end
    end

    // The miss cycle itself stalls, so MemStall is decoded from state and the live miss request.
    always_comb begin
        state_nxt    = state;
        miss_cnt_nxt = miss_cnt;
        timeout_nxt  = MissTimeout;
        MemStall     = 1'b0;
        case (state)
            RUN: begin
                if (DCacheMissM) begin
                    MemStall     = 1'b1;
                    state_nxt    = MISS;
                    miss_cnt_nxt = '0;
                end
            end
            MISS: begin
                MemStall = 1'b1;
                if (miss_cnt != MISS_CNT_MAX) begin
                    miss_cnt_nxt = miss_cnt + MISS_CNT_W'(1);
                end
                if (miss_cnt_nxt == MISS_CNT_MAX) begin
                    timeout_nxt = 1'b1;
                end
                if (DCacheReadyM) begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                MemStall  = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

endmodule

// File: rtl/hazard_controller.sv
// Central hazard unit for the 5-stage pipeline: load-use stalls, redirect flushes,
// E-stage forwarding, cache-miss freeze and performance counters.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned MISS_TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_W-1:0]   Rs1D,
    input  logic [REG_ADDR_W-1:0]   Rs2D,
    input  logic [REG_ADDR_W-1:0]   Rs1E,
    input  logic [REG_ADDR_W-1:0]   Rs2E,
    input  logic [REG_ADDR_W-1:0]   RdE,
    input  logic [RESULT_SRC_W-1:0] ResultSrcE,
    input  logic                    PCSrcE,
    input  logic [REG_ADDR_W-1:0]   RdM,
    input  logic [REG_ADDR_W-1:0]   RdW,
    input  logic                    RegWriteM,
    input  logic                    RegWriteW,
    input  logic                    DCacheMissM,
    input  logic                    DCacheReadyM,
    output logic                    StallF,
    output logic                    StallD,
    output logic                    FlushD,
    output logic                    FlushE,
    output logic                    StallE,
    output logic                    StallM,
    output logic                    StallW,
    output logic [1:0]              ForwardAE,
    output logic [1:0]              ForwardBE,
    output logic [CNT_WIDTH-1:0]    StallCycles,
    output logic [CNT_WIDTH-1:0]    FlushCount,
    output logic                    MissTimeout
);

    logic       mem_stall_raw;
    logic       mem_stall;
    logic       lw_stall;
    logic       any_stall;
    logic       redirect;
    pipe_ctrl_t ctrl;

    mem_stall_fsm #(
        .MISS_TIMEOUT (MISS_TIMEOUT)
    ) u_mem_stall_fsm (
        .clk          (clk),
        .rst          (rst),
        .DCacheMissM  (DCacheMissM),
        .DCacheReadyM (DCacheReadyM),
        .MemStall     (mem_stall_raw),
        .MissTimeout  (MissTimeout)
    );

    // FSM state is not yet cleared in the first reset cycle, so mask it here.
    assign mem_stall = mem_stall_raw & ~rst;

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // A cache freeze holds every stage (including W, so W-forwarding stays valid for the frozen E op)
    // and defers any pending redirect or load-use bubble until release.
    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.flush_d = 1'b1;
            ctrl.flush_e = 1'b1;
        end else if (mem_stall) begin
            ctrl.stall_f = 1'b1;
            ctrl.stall_d = 1'b1;
            ctrl.stall_e = 1'b1;
            ctrl.stall_m = 1'b1;
            ctrl.stall_w = 1'b1;
        end else begin
            ctrl.stall_f = lw_stall;
            ctrl.stall_d = lw_stall;
            ctrl.flush_d = PCSrcE;
            ctrl.flush_e = lw_stall | PCSrcE;
        end
    end

    assign StallF = ctrl.stall_f;
    assign StallD = ctrl.stall_d;
    assign StallE = ctrl.stall_e;
    assign StallM = ctrl.stall_m;
    assign StallW = ctrl.stall_w;
    assign FlushD = ctrl.flush_d;
    assign FlushE = ctrl.flush_e;

    assign ForwardAE = rst ? FWD_NONE : fwd_select(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = rst ? FWD_NONE : fwd_select(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

    assign any_stall = ctrl.stall_f | ctrl.stall_d | ctrl.stall_e | ctrl.stall_m | ctrl.stall_w;
    assign redirect  = PCSrcE & ~mem_stall;

    // Free-running performance counters, wrapping at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (any_stall) begin
                StallCycles <= StallCycles + CNT_WIDTH'(1);
            end
            if (redirect) begin
                FlushCount <= FlushCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: vector table for single-cycle hazards and forwarding,
// hand sequences for cache-miss freeze, deferred redirect, back-to-back miss, watchdog and reset.
module tb_hazard_controller;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, RegWriteM, RegWriteW, DCacheMissM, DCacheReadyM;
    logic        StallF, StallD, FlushD, FlushE, StallE, StallM, StallW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCycles, FlushCount;
    logic        MissTimeout;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_controller #(
        .CNT_WIDTH    (32),
        .MISS_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .ResultSrcE   (ResultSrcE),
        .PCSrcE       (PCSrcE),
        .RdM          (RdM),
        .RdW          (RdW),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .DCacheMissM  (DCacheMissM),
        .DCacheReadyM (DCacheReadyM),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .StallE       (StallE),
        .StallM       (StallM),
        .StallW       (StallW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .StallCycles  (StallCycles),
        .FlushCount   (FlushCount),
        .MissTimeout  (MissTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pcsrc;
        logic [4:0] rdm, rdw;
        logic       wm, ww;
        logic [3:0] exp_sf_sd_fd_fe;
        logic [1:0] exp_fa, exp_fb;
        int         exp_dstall, exp_dflush;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic [4:0] rs1d, input logic [4:0] rs2d, input logic [4:0] rs1e,
        input logic [4:0] rs2e, input logic [4:0] rde, input logic [1:0] rsrc,
        input logic pcsrc, input logic [4:0] rdm, input logic [4:0] rdw,
        input logic wm, input logic ww, input logic [3:0] ctl,
        input logic [1:0] fa, input logic [1:0] fb, input int dst, input int dfl);
        vec_t v;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
        v.rsrc = rsrc; v.pcsrc = pcsrc; v.rdm = rdm; v.rdw = rdw; v.wm = wm; v.ww = ww;
        v.exp_sf_sd_fd_fe = ctl; v.exp_fa = fa; v.exp_fb = fb;
        v.exp_dstall = dst; v.exp_dflush = dfl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        ResultSrcE = '0; PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        DCacheMissM = 1'b0; DCacheReadyM = 1'b0;
    endtask

    function automatic logic [4:0] stalls();
        return {StallF, StallD, StallE, StallM, StallW};
    endfunction

    // Reset for one cycle with hazard-provoking inputs; returns at a negedge with rst low.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5; PCSrcE = 1'b1;
        #1;
        check({tag, "_rst_stalls"}, 32'(stalls()), 32'h0);
        check({tag, "_rst_flush"}, 32'({FlushD, FlushE}), 32'h3);
        check({tag, "_rst_fwd"}, 32'({ForwardAE, ForwardBE}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        logic [31:0] sc0, fc0;
        logic [7:0]  miss_pat, ready_pat, stall_pat;

        rst = 1'b1;
        idle_inputs();
        //            rs1d rs2d rs1e rs2e rde rsrc pc rdm rdw wm ww  SF SD FD FE   fa     fb    dst dfl
        vecs[0]  = mk(5,   0,   0,   0,   5,  1,   0, 0,  0,  0, 0, 4'b1101, 2'b00, 2'b00, 1, 0);
        vecs[1]  = mk(5,   0,   0,   0,   0,  1,   0, 0,  0,  0, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
        vecs[2]  = mk(1,   9,   0,   0,   9,  1,   0, 0,  0,  0, 0, 4'b1101, 2'b00, 2'b00, 1, 0);
        vecs[3]  = mk(5,   0,   0,   0,   5,  2,   0, 0,  0,  0, 0, 4'b0000, 2'b00, 2'b00, 0, 0);
        vecs[4]  = mk(0,   0,   7,   7,   0,  0,   0, 7,  7,  1, 1, 4'b0000, 2'b10, 2'b10, 0, 0);
        vecs[5]  = mk(0,   0,   7,   7,   0,  0,   0, 7,  7,  0, 1, 4'b0000, 2'b01, 2'b01, 0, 0);
        vecs[6]  = mk(0,   0,   0,   7,   0,  0,   0, 7,  7,  0, 1, 4'b0000, 2'b00, 2'b01, 0, 0);
        vecs[7]  = mk(0,   0,   0,   0,   0,  0,   0, 0,  0,  1, 1, 4'b0000, 2'b00, 2'b00, 0, 0);
        vecs[8]  = mk(0,   0,   4,   3,   0,  0,   0, 3,  4,  1, 1, 4'b0000, 2'b01, 2'b10, 0, 0);
        vecs[9]  = mk(0,   0,   0,   0,   0,  0,   1, 0,  0,  0, 0, 4'b0011, 2'b00, 2'b00, 0, 1);
        vecs[10] = mk(5,   0,   0,   0,   5,  1,   1, 0,  0,  0, 0, 4'b1111, 2'b00, 2'b00, 1, 1);
        vecs[11] = mk(0,   0,   6,   6,   0,  0,   0, 6,  6,  0, 0, 4'b0000, 2'b00, 2'b00, 0, 0);

        // Power-on reset and counter start values.
        do_reset("por");
        #1;
        check("por_stallcycles", StallCycles, 32'd0);
        check("por_flushcount", FlushCount, 32'd0);
        check("por_timeout", 32'(MissTimeout), 32'd0);

        // Single-cycle hazards and forwarding.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; ResultSrcE = vecs[i].rsrc; PCSrcE = vecs[i].pcsrc;
            RdM = vecs[i].rdm; RdW = vecs[i].rdw; RegWriteM = vecs[i].wm; RegWriteW = vecs[i].ww;
            #1;
            check($sformatf("vec%0d_ctl", i), 32'({StallF, StallD, FlushD, FlushE}),
                  32'(vecs[i].exp_sf_sd_fd_fe));
            check($sformatf("vec%0d_stall_emw", i), 32'({StallE, StallM, StallW}), 32'h0);
            check($sformatf("vec%0d_fwd_a", i), 32'(ForwardAE), 32'(vecs[i].exp_fa));
            check($sformatf("vec%0d_fwd_b", i), 32'(ForwardBE), 32'(vecs[i].exp_fb));
            sc0 = StallCycles;
            fc0 = FlushCount;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_dstall", i), StallCycles - sc0, 32'(vecs[i].exp_dstall));
            check($sformatf("vec%0d_dflush", i), FlushCount - fc0, 32'(vecs[i].exp_dflush));
        end

        // Miss at cycle 0, refill pulse at cycle 4: frozen cycles 0..5, released at 6.
        do_reset("miss");
        for (int c = 0; c < 8; c++) begin
            DCacheMissM = (c <= 5);
            DCacheReadyM = (c == 4);
            #1;
            check($sformatf("miss_c%0d_stalls", c), 32'(stalls()), (c <= 5) ? 32'h1f : 32'h0);
            check($sformatf("miss_c%0d_flush", c), 32'({FlushD, FlushE}), 32'h0);
            check($sformatf("miss_c%0d_stallcycles", c), StallCycles, 32'((c <= 6) ? c : 6));
            @(negedge clk);
        end

        // Redirect and load-use held through a miss take effect on the first RUN cycle.
        do_reset("defer");
        for (int c = 0; c < 6; c++) begin
            PCSrcE = (c <= 4);
            ResultSrcE = (c <= 4) ? 2'b01 : 2'b00;
            RdE = 5'd5; Rs1D = 5'd5;
            DCacheMissM = (c <= 1);
            DCacheReadyM = (c == 2);
            #1;
            if (c <= 3) begin
                check($sformatf("defer_c%0d_stalls", c), 32'(stalls()), 32'h1f);
                check($sformatf("defer_c%0d_flush", c), 32'({FlushD, FlushE}), 32'h0);
                check($sformatf("defer_c%0d_flushcount", c), FlushCount, 32'd0);
            end else if (c == 4) begin
                check("defer_release_stalls", 32'(stalls()), 32'h18);
                check("defer_release_flush", 32'({FlushD, FlushE}), 32'h3);
                check("defer_release_flushcount", FlushCount, 32'd0);
            end else begin
                check("defer_after_flushcount", FlushCount, 32'd1);
                check("defer_after_stallcycles", StallCycles, 32'd5);
            end
            @(negedge clk);
        end

        // Miss right after REFILL is a new miss; ready outside MISS is ignored.
        do_reset("b2b");
        miss_pat  = 8'b0000_1101;
        ready_pat = 8'b0111_0010;
        stall_pat = 8'b0011_1111;
        for (int c = 0; c < 8; c++) begin
            DCacheMissM = miss_pat[c];
            DCacheReadyM = ready_pat[c];
            #1;
            check($sformatf("b2b_c%0d_stalls", c), 32'(stalls()), stall_pat[c] ? 32'h1f : 32'h0);
            @(negedge clk);
        end

        // Watchdog: no refill, sticky flag after 4 MISS cycles; reset mid-MISS clears everything.
        do_reset("wdog");
        for (int c = 0; c < 9; c++) begin
            DCacheMissM = 1'b1;
            #1;
            check($sformatf("wdog_c%0d_stalls", c), 32'(stalls()), 32'h1f);
            check($sformatf("wdog_c%0d_timeout", c), 32'(MissTimeout), 32'((c >= 5) ? 1 : 0));
            @(negedge clk);
        end
        check("wdog_stallcycles", StallCycles, 32'd9);
        rst = 1'b1;
        PCSrcE = 1'b1;
        #1;
        check("wdog_rst_stalls", 32'(stalls()), 32'h0);
        check("wdog_rst_flush", 32'({FlushD, FlushE}), 32'h3);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        check("wdog_post_stalls", 32'(stalls()), 32'h0);
        check("wdog_post_stallcycles", StallCycles, 32'd0);
        check("wdog_post_flushcount", FlushCount, 32'd0);
        check("wdog_post_timeout", 32'(MissTimeout), 32'd0);
        @(negedge clk);
        #1;
        check("wdog_run_stalls", 32'(stalls()), 32'h0);
        check("wdog_run_stallcycles", StallCycles, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
